// File: rtl/mtc_builder_matched.sv
// MTC builder with per-thread candidate buffering: matches returning ptcalc results to
// busy SL candidates by MUID, applies timeouts and spreads finished packets round-robin over the output lanes.
module mtc_builder_matched #(
  parameter  int N_SL           = 3,
  parameter  int N_THREADS      = 3,
  parameter  int N_OUT          = 3,
  parameter  int FIFO_DEPTH     = 8,
  parameter  int TIMEOUT        = 64,
  parameter  int CNT_W          = 16,
  localparam int PL2MTC_LEN     = 46,
  localparam int PTCALC2MTC_LEN = 43,
  localparam int MTC2SL_LEN     = 81
) (
  input  logic                                      clock,
  input  logic                                      rst,
  input  logic [N_SL-1:0][PL2MTC_LEN-1:0]           slcpipeline,
  input  logic [N_THREADS-1:0][PTCALC2MTC_LEN-1:0]  ptcalc,
  output logic [N_OUT-1:0][MTC2SL_LEN-1:0]          mtc,
  output logic [CNT_W-1:0]                          drop_cnt,
  output logic [CNT_W-1:0]                          timeout_cnt,
  output logic [CNT_W-1:0]                          mismatch_cnt
);

  // Candidate: [45] valid, [44] busy, [43:40] process_ch, [39:0] common fields
  //   (common: [39:37] cointype, [36] charge, [35:32] ptthresh, [31:24] pt, [23:16] phi, [15:8] eta, [7:0] muid)
  // Ptcalc: [42] valid, [41:39] nseg, [38:37] quality, [36] charge, [35:32] ptthresh, [31:24] pt,
  //   [23:16] phi, [15:8] eta, [7:0] muid; [41:8] forms the MDT block copied into the packet
  // Packet: [80] valid, [79:78] reserved, [77:74] procflags, [73:40] MDT block, [39:0] common fields
  localparam int COM_W    = 40;
  localparam int MDT_W    = 34;
  localparam int PKT_W    = 4 + MDT_W + COM_W;
  localparam int NS       = N_THREADS + N_SL;
  localparam int SRC_W    = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW       = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int AGE_W    = $clog2(TIMEOUT);
  localparam int PL_VALID = 45;
  localparam int PL_BUSY  = 44;
  localparam int PT_VALID = 42;

  function automatic logic [3:0] proc_flags(input logic [2:0] cointype, input logic [3:0] sl_pth,
                                            input logic [7:0] pt, input logic [3:0] mdt_pth,
                                            input logic [2:0] nseg);
    if (pt != 8'd0 && mdt_pth >= sl_pth)   return 4'h1;
    else if (pt != 8'd0)                   return 4'h2;
    else if (cointype == 3'd0 && nseg == 3'd0) return 4'h4;
    else if (cointype == 3'd0 && nseg == 3'd1) return 4'h5;
    else if (nseg > 3'd2)                  return 4'h6;
    else                                   return 4'hF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [7:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic [COM_W-1:0]                  r_fifo [N_THREADS][FIFO_DEPTH];
  logic [N_THREADS-1:0][AW-1:0]      r_rd;
  logic [N_THREADS-1:0][AW-1:0]      r_wr;
  logic [N_THREADS-1:0][AW:0]        r_cnt;
  logic [N_THREADS-1:0][AGE_W-1:0]   r_age;
  logic [NS-1:0]                     r_src_vld_p0;
  logic [NS-1:0][PKT_W-1:0]          r_src_pkt_p0;
  logic [SRC_W-1:0]                  r_rr;
  logic [N_OUT-1:0][MTC2SL_LEN-1:0]  r_mtc_p1;
  logic [CNT_W-1:0]                  r_drop_cnt;
  logic [CNT_W-1:0]                  r_timeout_cnt;
  logic [CNT_W-1:0]                  r_mismatch_cnt;

  logic [NS-1:0]                     w_gnt;
  logic [N_OUT-1:0][MTC2SL_LEN-1:0]  w_mtc_nxt;
  logic [SRC_W-1:0]                  w_rr_nxt;

  logic [N_THREADS-1:0][COM_W-1:0]   w_head;
  logic [N_THREADS-1:0][PKT_W-1:0]   w_tpkt;
  logic [N_THREADS-1:0]              w_empty, w_match, w_mism, w_tmo_evt, w_tfree;
  logic [N_THREADS-1:0]              w_tload, w_tdrop, w_tmo, w_pop;

  logic [N_SL-1:0]                   w_push, w_bload;
  logic [N_SL-1:0][TW-1:0]           w_push_t;
  logic [N_SL-1:0][AW-1:0]           w_push_slot;
  logic [N_SL-1:0][PKT_W-1:0]        w_bpkt;
  logic [N_THREADS-1:0][AW:0]        w_npush;
  logic [7:0]                        w_drop_inc, w_tmo_inc, w_mism_inc;

  // Stage p0 -> p1: round-robin grant of occupied source registers onto the lanes
  always_comb begin
    int k;
    int idx;
    k         = 0;
    idx       = 0;
    w_gnt     = '0;
    w_mtc_nxt = '0;
    w_rr_nxt  = r_rr;
    for (int i = 0; i < NS; i++) begin
      idx = int'(r_rr) + i;
      if (idx >= NS) idx = idx - NS;
      if (r_src_vld_p0[idx] && k < N_OUT) begin
        w_gnt[idx]   = 1'b1;
        w_mtc_nxt[k] = {1'b1, 2'b00, r_src_pkt_p0[idx]};
        k            = k + 1;
        w_rr_nxt     = (idx == NS - 1) ? '0 : SRC_W'(idx + 1);
      end
    end
  end

  // A source register may take a new packet if empty or being drained this cycle
  always_comb begin
    for (int t = 0; t < N_THREADS; t++) begin
      w_head[t]    = r_fifo[t][r_rd[t]];
      w_empty[t]   = (r_cnt[t] == '0);
      w_match[t]   = ptcalc[t][PT_VALID] && !w_empty[t] && (ptcalc[t][7:0] == w_head[t][7:0]);
      w_mism[t]    = ptcalc[t][PT_VALID] && !w_match[t];
      w_tmo_evt[t] = !w_empty[t] && !w_match[t] && (r_age[t] == AGE_W'(TIMEOUT - 1));
      w_tfree[t]   = !r_src_vld_p0[t] || w_gnt[t];
      w_tload[t]   = (w_match[t] || w_tmo_evt[t]) && w_tfree[t];
      w_tdrop[t]   = (w_match[t] || w_tmo_evt[t]) && !w_tfree[t];
      w_tmo[t]     = w_tmo_evt[t] && w_tfree[t];
      w_pop[t]     = w_tload[t];
      if (w_match[t])
        w_tpkt[t] = {proc_flags(w_head[t][39:37], w_head[t][35:32], ptcalc[t][31:24],
                                ptcalc[t][35:32], ptcalc[t][41:39]),
                     ptcalc[t][41:8], w_head[t]};
      else
        w_tpkt[t] = {4'hD, {MDT_W{1'b0}}, w_head[t]};
    end
    w_tmo_inc  = 8'($countones(w_tmo));
    w_mism_inc = 8'($countones(w_mism));
  end

  // Candidate routing; pushes into one FIFO are taken in ascending SL order
  always_comb begin
    int ndrop;
    int ch;
    ndrop       = 0;
    ch          = 0;
    w_push      = '0;
    w_bload     = '0;
    w_push_t    = '0;
    w_push_slot = '0;
    w_bpkt      = '0;
    w_npush     = '0;
    for (int t = 0; t < N_THREADS; t++)
      if (w_tdrop[t]) ndrop = ndrop + 1;
    for (int s = 0; s < N_SL; s++) begin
      ch = int'(slcpipeline[s][43:40]);
      if (slcpipeline[s][PL_VALID] && slcpipeline[s][PL_BUSY] && ch < N_THREADS) begin
        w_push_t[s] = TW'(ch);
        if (int'(w_npush[ch]) < FIFO_DEPTH - int'(r_cnt[ch]) + int'(w_pop[ch])) begin
          w_push[s]      = 1'b1;
          w_push_slot[s] = r_wr[ch] + w_npush[ch][AW-1:0];
          w_npush[ch]    = w_npush[ch] + (AW+1)'(1);
        end else begin
          ndrop = ndrop + 1;
        end
      end else if (slcpipeline[s][PL_VALID]) begin
        w_bpkt[s] = {(slcpipeline[s][PL_BUSY] ? 4'hE : 4'h0), {MDT_W{1'b0}},
                     slcpipeline[s][COM_W-1:0]};
        if (!r_src_vld_p0[N_THREADS+s] || w_gnt[N_THREADS+s]) w_bload[s] = 1'b1;
        else ndrop = ndrop + 1;
      end
    end
    w_drop_inc = 8'(ndrop);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_mtc_p1       <= '0;
      r_rr           <= '0;
      r_src_vld_p0   <= '0;
      r_src_pkt_p0   <= '0;
      r_rd           <= '0;
      r_wr           <= '0;
      r_cnt          <= '0;
      r_age          <= '0;
      r_drop_cnt     <= '0;
      r_timeout_cnt  <= '0;
      r_mismatch_cnt <= '0;
    end else begin
      r_mtc_p1 <= w_mtc_nxt;
      r_rr     <= w_rr_nxt;
      for (int i = 0; i < NS; i++)
        if (w_gnt[i]) r_src_vld_p0[i] <= 1'b0;
      for (int t = 0; t < N_THREADS; t++)
        if (w_tload[t]) begin
          r_src_vld_p0[t] <= 1'b1;
          r_src_pkt_p0[t] <= w_tpkt[t];
        end
      for (int s = 0; s < N_SL; s++)
        if (w_bload[s]) begin
          r_src_vld_p0[N_THREADS+s] <= 1'b1;
          r_src_pkt_p0[N_THREADS+s] <= w_bpkt[s];
        end
      for (int t = 0; t < N_THREADS; t++) begin
        r_rd[t]  <= r_rd[t] + AW'(w_pop[t]);
        r_wr[t]  <= r_wr[t] + w_npush[t][AW-1:0];
        r_cnt[t] <= r_cnt[t] + w_npush[t] - (AW+1)'(w_pop[t]);
        // Age restarts whenever a new candidate becomes head; a blocked head holds at the limit
        if (w_pop[t] || (w_empty[t] && w_npush[t] != '0))
          r_age[t] <= '0;
        else if (!w_empty[t] && r_age[t] != AGE_W'(TIMEOUT - 1))
          r_age[t] <= r_age[t] + AGE_W'(1);
        else if (w_empty[t])
          r_age[t] <= '0;
      end
      r_drop_cnt     <= sat_add(r_drop_cnt, w_drop_inc);
      r_timeout_cnt  <= sat_add(r_timeout_cnt, w_tmo_inc);
      r_mismatch_cnt <= sat_add(r_mismatch_cnt, w_mism_inc);
    end
  end

  always_ff @(posedge clock) begin
    for (int s = 0; s < N_SL; s++)
      if (w_push[s]) r_fifo[w_push_t[s]][w_push_slot[s]] <= slcpipeline[s][COM_W-1:0];
  end

  assign mtc          = r_mtc_p1;
  assign drop_cnt     = r_drop_cnt;
  assign timeout_cnt  = r_timeout_cnt;
  assign mismatch_cnt = r_mismatch_cnt;

endmodule
